// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: shared Q8.8 constants and the round/saturate helper
package nn_fixed_pkg;
  localparam int Q_FRAC_BITS = 8;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;
  function automatic logic [15:0] round_sat(input logic signed [63:0] sum, input int frac_bits, input logic relu);
    logic signed [63:0] s;
    logic [15:0] r;
    s = (sum + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    r = s > 64'sd32767 ? Q_MAX : s < -64'sd32768 ? Q_MIN : s[15:0];
    return (relu && r[15]) ? 16'h0000 : r;
  endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one lane of multiply, accumulate and round/saturate to Q8.8
module mac_lane
  import nn_fixed_pkg::*;
#(
  parameter int ACC_WIDTH = 40,
  parameter int FRAC_BITS = Q_FRAC_BITS,
  parameter bit RELU = 1'b1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        load,
  input  logic        prod_valid,
  input  logic        prod_last,
  input  logic        sum_valid,
  input  logic [15:0] a,
  input  logic [15:0] w,
  output logic [15:0] result
);
  logic signed [31:0] prod;
  logic signed [ACC_WIDTH-1:0] acc, sum, acc_next;
  logic [31:0] a_ext, w_ext;
  assign a_ext = {{16{a[15]}}, a};
  assign w_ext = {{16{w[15]}}, w};
  assign acc_next = acc + {{(ACC_WIDTH-32){prod[31]}}, prod};
  always_ff @(posedge clock) begin
    if (clear) begin
      prod <= '0;
      acc <= '0;
      sum <= '0;
      result <= '0;
    end else begin
      if (load) prod <= a_ext * w_ext;
      if (prod_valid) acc <= prod_last ? '0 : acc_next;
      if (prod_valid && prod_last) sum <= acc_next;
      if (sum_valid) result <= round_sat(64'(sum), FRAC_BITS, RELU);
    end
  end
endmodule

// File: rtl/neuron_mac_accumulator.sv
// neuron_mac_accumulator: four-lane Q8.8 dot-product MAC with element counter and result pulse
module neuron_mac_accumulator
  import nn_fixed_pkg::*;
#(
  parameter int DOT_LENGTH = 256,
  parameter int FRAC_BITS = Q_FRAC_BITS,
  parameter int ACC_WIDTH = 40,
  parameter bit RELU = 1'b1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        a_element_ready,
  input  logic [15:0] a0_element,
  input  logic [15:0] a1_element,
  input  logic [15:0] a2_element,
  input  logic [15:0] a3_element,
  input  logic [15:0] w0_element,
  input  logic [15:0] w1_element,
  input  logic [15:0] w2_element,
  input  logic [15:0] w3_element,
  output logic        result_valid,
  output logic [15:0] result0,
  output logic [15:0] result1,
  output logic [15:0] result2,
  output logic [15:0] result3,
  output logic [7:0]  neuron_count,
  output logic        busy
);
  localparam int CW = DOT_LENGTH > 1 ? $clog2(DOT_LENGTH) : 1;
  logic [CW-1:0] count;
  logic prod_valid, prod_last, sum_valid;
  logic [15:0] a [4];
  logic [15:0] w [4];
  logic [15:0] r [4];
  assign a = '{a0_element, a1_element, a2_element, a3_element};
  assign w = '{w0_element, w1_element, w2_element, w3_element};
  assign {result0, result1, result2, result3} = {r[0], r[1], r[2], r[3]};
  assign busy = |count | prod_valid | sum_valid;
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
      prod_valid <= 1'b0;
      prod_last <= 1'b0;
      sum_valid <= 1'b0;
      result_valid <= 1'b0;
      neuron_count <= '0;
    end else begin
      if (a_element_ready) count <= count + CW'(1);
      prod_valid <= a_element_ready;
      prod_last <= a_element_ready & (&count);
      sum_valid <= prod_valid & prod_last;
      result_valid <= sum_valid;
      neuron_count <= neuron_count + 8'(sum_valid);
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_lane
    mac_lane #(.ACC_WIDTH(ACC_WIDTH), .FRAC_BITS(FRAC_BITS), .RELU(RELU)) u_lane (
      .clock(clock),
      .clear(clear),
      .load(a_element_ready),
      .prod_valid(prod_valid),
      .prod_last(prod_last),
      .sum_valid(sum_valid),
      .a(a[i]),
      .w(w[i]),
      .result(r[i])
    );
  end
endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// tb_neuron_mac_accumulator: scoreboard bench driving a ReLU and a linear instance in parallel
module tb_neuron_mac_accumulator;
  logic clock = 1'b0;
  logic clear = 1'b1;
  logic ready = 1'b0;
  logic [63:0] a_el = '0;
  logic [63:0] w_el = '0;
  logic [15:0] res_r [4];
  logic [15:0] res_l [4];
  logic val_r, val_l, busy_r, busy_l;
  logic [7:0] cnt_r, cnt_l;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int pushes = 0;
  typedef struct {
    logic [63:0] r;
    logic [63:0] l;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;
  exp_t q [$];
  longint acc [4] = '{0, 0, 0, 0};
  int ecnt = 0;
  logic [7:0] exp_cnt = '0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  neuron_mac_accumulator #(.DOT_LENGTH(4), .FRAC_BITS(8), .ACC_WIDTH(40), .RELU(1'b1)) u_relu (
    .clock(clock), .clear(clear), .a_element_ready(ready),
    .a0_element(a_el[15:0]), .a1_element(a_el[31:16]), .a2_element(a_el[47:32]), .a3_element(a_el[63:48]),
    .w0_element(w_el[15:0]), .w1_element(w_el[31:16]), .w2_element(w_el[47:32]), .w3_element(w_el[63:48]),
    .result_valid(val_r), .result0(res_r[0]), .result1(res_r[1]), .result2(res_r[2]), .result3(res_r[3]),
    .neuron_count(cnt_r), .busy(busy_r)
  );
  neuron_mac_accumulator #(.DOT_LENGTH(4), .FRAC_BITS(8), .ACC_WIDTH(40), .RELU(1'b0)) u_lin (
    .clock(clock), .clear(clear), .a_element_ready(ready),
    .a0_element(a_el[15:0]), .a1_element(a_el[31:16]), .a2_element(a_el[47:32]), .a3_element(a_el[63:48]),
    .w0_element(w_el[15:0]), .w1_element(w_el[31:16]), .w2_element(w_el[47:32]), .w3_element(w_el[63:48]),
    .result_valid(val_l), .result0(res_l[0]), .result1(res_l[1]), .result2(res_l[2]), .result3(res_l[3]),
    .neuron_count(cnt_l), .busy(busy_l)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] fin(input longint sum, input bit relu);
    longint s;
    logic [15:0] v;
    s = (sum + 128) >>> 8;
    v = s > 32767 ? 16'h7FFF : s < -32768 ? 16'h8000 : 16'(s);
    return (relu && v[15]) ? 16'h0000 : v;
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic send(input logic [63:0] av, input logic [63:0] wv);
    exp_t e;
    a_el = av;
    w_el = wv;
    ready = 1'b1;
    for (int i = 0; i < 4; i++)
      acc[i] += longint'($signed(av[16*i +: 16])) * longint'($signed(wv[16*i +: 16]));
    ecnt++;
    if (ecnt == 4) begin
      for (int i = 0; i < 4; i++) begin
        e.r[16*i +: 16] = fin(acc[i], 1'b1);
        e.l[16*i +: 16] = fin(acc[i], 1'b0);
        acc[i] = 0;
      end
      exp_cnt++;
      e.cnt = exp_cnt;
      e.cyc = cyc + 3;
      q.push_back(e);
      pushes++;
      ecnt = 0;
    end
    @(posedge clock);
    #1;
    ready = 1'b0;
  endtask
  task automatic do_clear(input logic with_ready);
    clear = 1'b1;
    ready = with_ready;
    a_el = {4{16'h0100}};
    w_el = {4{16'h0100}};
    @(posedge clock);
    #1;
    clear = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    ecnt = 0;
    exp_cnt = '0;
    q.delete();
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain", 64'(q.size()), 64'd0);
    q.delete();
    idle(1);
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (val_r || val_l) begin
      check("valid_pair", 64'(val_l), 64'(val_r));
      pulses++;
      if (q.size() == 0) check("spurious_pulse", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        check("latency_cyc", 64'(cyc), 64'(e.cyc));
        check("res_relu", {res_r[3], res_r[2], res_r[1], res_r[0]}, e.r);
        check("res_lin", {res_l[3], res_l[2], res_l[1], res_l[0]}, e.l);
        check("ncount", 64'(cnt_r), 64'(e.cnt));
      end
    end
  end
  initial begin
    idle(2);
    clear = 1'b0;
    check("rst_valid", 64'({val_r, val_l}), 64'd0);
    check("rst_count", 64'({cnt_r, cnt_l}), 64'd0);
    check("rst_busy", 64'({busy_r, busy_l}), 64'd0);
    check("rst_res", {res_r[0], res_r[1], res_r[2], res_r[3]}, 64'd0);
    send({16'h8000, 16'h7FFF, 16'hFF00, 16'h0100}, {16'h7FFF, 16'h7FFF, 16'h0100, 16'h0200});
    check("busy_mid", 64'(busy_r), 64'd1);
    repeat (3) send({16'h8000, 16'h7FFF, 16'hFF00, 16'h0100}, {16'h7FFF, 16'h7FFF, 16'h0100, 16'h0200});
    drain();
    check("t1_r0", 64'(res_r[0]), 64'h0800);
    check("t2_r1_relu", 64'(res_r[1]), 64'h0000);
    check("t2_r1_lin", 64'(res_l[1]), 64'hFC00);
    check("t3_r2_sat", 64'(res_r[2]), 64'h7FFF);
    check("t3_r3_lin", 64'(res_l[3]), 64'h8000);
    check("busy_idle", 64'(busy_r), 64'd0);
    do_clear(1'b0);
    for (int k = 0; k < 8; k++) send(64'h0100, k < 4 ? 64'h0100 : 64'h0300);
    drain();
    check("t4_r0", 64'(res_r[0]), 64'h0C00);
    check("t4_count", 64'(cnt_r), 64'd2);
    do_clear(1'b0);
    for (int k = 0; k < 40; k++) begin
      send({$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(1) == 1) idle(1);
    end
    drain();
    check("t5_pulses", 64'(pulses), 64'(pushes));
    do_clear(1'b0);
    send(64'h0100, 64'h0100);
    send(64'h0100, 64'h0100);
    do_clear(1'b1);
    idle(6);
    check("t6_count_clr", 64'(cnt_r), 64'd0);
    check("t6_busy_clr", 64'(busy_r), 64'd0);
    repeat (4) send(64'h0100, 64'h0100);
    drain();
    check("t6_r0", 64'(res_r[0]), 64'h0400);
    check("t6_count", 64'(cnt_r), 64'd1);
    check("t6_pulses", 64'(pulses), 64'(pushes));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
